// File: rtl/pipe_stage_chain_if.sv
// Handshake and control bundle for pipe_stage_chain: upstream/downstream
// valid-ready pairs, flush controls and the occupancy report.
interface pipe_stage_chain_if #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
);
    localparam int OCC_W = $clog2(STAGES + 1);

    logic                 in_valid;
    logic [WIDTH-1:0]     in_data;
    logic                 in_ready;
    logic                 out_valid;
    logic [WIDTH-1:0]     out_data;
    logic                 out_ready;
    logic [STAGES-1:0]    flush;
    logic                 flush_all;
    logic [OCC_W-1:0]     occupancy;

    // master drives the chain (producer, consumer and flush control)
    modport master (
        output in_valid, in_data, out_ready, flush, flush_all,
        input  in_ready, out_valid, out_data, occupancy
    );

    modport slave (
        input  in_valid, in_data, out_ready, flush, flush_all,
        output in_ready, out_valid, out_data, occupancy
    );
endinterface

// File: rtl/pipe_stage_chain.sv
// Elastic chain of STAGES valid/data registers with bubble collapsing,
// per-stage and global flush, and a registered live-entry count.
module pipe_stage_chain #(
    parameter int               WIDTH  = 32,
    parameter int               STAGES = 4,
    parameter logic [WIDTH-1:0] NOP    = WIDTH'(32'h0000_0013)
) (
    input logic               clk,
    input logic               reset,
    pipe_stage_chain_if.slave bus
);
    localparam int OCC_W = $clog2(STAGES + 1);
    localparam int LAST  = STAGES - 1;

    logic [STAGES-1:0] v;
    logic [WIDTH-1:0]  d [STAGES];

    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] free;
    logic [STAGES-1:0] v_next;
    logic [WIDTH-1:0]  d_next [STAGES];
    logic [OCC_W-1:0]  occ_next;
    logic [OCC_W-1:0]  occ;
    logic              take;

    // Readiness ripples from the output back toward stage 0, which lets
    // younger entries close up behind a stalled older one.
    always_comb begin
        adv       = '0;
        free      = '0;
        adv[LAST]  = v[LAST] & ~bus.flush[LAST] & bus.out_ready;
        free[LAST] = ~v[LAST] | bus.flush[LAST] | adv[LAST];
        for (int i = LAST - 1; i >= 0; i--) begin
            adv[i]  = v[i] & ~bus.flush[i] & free[i+1];
            free[i] = ~v[i] | bus.flush[i] | adv[i];
        end
    end

    assign bus.in_ready = free[0] & ~bus.flush_all;
    assign take         = bus.in_valid & bus.in_ready;

    always_comb begin
        v_next   = '0;
        occ_next = '0;
        for (int i = 0; i < STAGES; i++) begin
            d_next[i] = NOP;
        end

        if (take) begin
            v_next[0] = 1'b1;
            d_next[0] = bus.in_data;
        end else if (!free[0]) begin
            v_next[0] = v[0];
            d_next[0] = d[0];
        end

        for (int i = 1; i < STAGES; i++) begin
            if (adv[i-1]) begin
                v_next[i] = 1'b1;
                d_next[i] = d[i-1];
            end else if (!free[i]) begin
                v_next[i] = v[i];
                d_next[i] = d[i];
            end
        end

        // flush_all wins over every per-stage decision
        if (bus.flush_all) begin
            v_next = '0;
            for (int i = 0; i < STAGES; i++) begin
                d_next[i] = NOP;
            end
        end

        for (int i = 0; i < STAGES; i++) begin
            occ_next = occ_next + OCC_W'(v_next[i]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v   <= '0;
            occ <= '0;
            for (int i = 0; i < STAGES; i++) begin
                d[i] <= NOP;
            end
        end else begin
            v   <= v_next;
            occ <= occ_next;
            for (int i = 0; i < STAGES; i++) begin
                d[i] <= d_next[i];
            end
        end
    end

    // A last-stage entry being flushed this cycle is never offered downstream.
    assign bus.out_valid = v[LAST] & ~bus.flush[LAST];
    assign bus.out_data  = bus.out_valid ? d[LAST] : NOP;
    assign bus.occupancy = occ;
endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed bench for pipe_stage_chain (WIDTH=32, STAGES=4) with
// hand-traced expectations for streaming, stall, collapse, flush and reset.
module tb_pipe_stage_chain;
    localparam int          WIDTH  = 32;
    localparam int          STAGES = 4;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic clk = 1'b0;
    logic reset;
    int   vectors     = 0;
    int   miscompares = 0;

    pipe_stage_chain_if #(.WIDTH(WIDTH), .STAGES(STAGES)) bus ();

    pipe_stage_chain #(
        .WIDTH (WIDTH),
        .STAGES(STAGES),
        .NOP   (NOP)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic iv, input logic [31:0] data, input logic ordy,
                                 input logic [3:0] fl, input logic fa);
        bus.in_valid  = iv;
        bus.in_data   = data;
        bus.out_ready = ordy;
        bus.flush     = fl;
        bus.flush_all = fa;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkState(input string tag, input logic valid, input logic [31:0] data,
                              input int occ);
        checkOutput({tag, "_valid"}, 32'(bus.out_valid), 32'(valid));
        checkOutput({tag, "_data"}, bus.out_data, data);
        checkOutput({tag, "_occ"}, 32'(bus.occupancy), 32'(occ));
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b1, 4'b0000, 1'b0);
        #3;
        checkState("reset", 1'b0, NOP, 0);
        tick();
        checkState("reset_clocked", 1'b0, NOP, 0);
        #2 reset = 1'b1;
        tick();

        $display("[TB] streaming 0x1..0x8");
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b1, 32'(k + 1), 1'b1, 4'b0000, 1'b0);
            #1 checkOutput("stream_in_ready", 32'(bus.in_ready), 32'd1);
            tick();
            if (k >= 3) checkState("stream", 1'b1, 32'(k - 2), 4);
            else        checkState("stream_fill", 1'b0, NOP, k + 1);
        end
        applyStimulus(1'b0, 32'h0, 1'b1, 4'b0000, 1'b0);
        for (int j = 0; j < 4; j++) begin
            tick();
            if (j < 3) checkState("stream_drain", 1'b1, 32'(6 + j), 3 - j);
            else       checkState("stream_empty", 1'b0, NOP, 0);
        end

        $display("[TB] stall with full chain");
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 32'hA + 32'(k), 1'b0, 4'b0000, 1'b0);
            #1 checkOutput("stall_fill_ready", 32'(bus.in_ready), 32'd1);
            tick();
        end
        applyStimulus(1'b1, 32'hEE, 1'b0, 4'b0000, 1'b0);
        #1;
        checkState("stall_full", 1'b1, 32'hA, 4);
        checkOutput("stall_in_ready", 32'(bus.in_ready), 32'd0);
        tick();
        checkState("stall_hold", 1'b1, 32'hA, 4);
        applyStimulus(1'b0, 32'h0, 1'b1, 4'b0000, 1'b0);
        for (int j = 0; j < 4; j++) begin
            tick();
            if (j < 3) checkState("stall_drain", 1'b1, 32'hB + 32'(j), 3 - j);
            else       checkState("stall_empty", 1'b0, NOP, 0);
        end

        $display("[TB] bubble collapse");
        applyStimulus(1'b1, 32'h10, 1'b0, 4'b0000, 1'b0); tick();
        checkOutput("collapse_occ0", 32'(bus.occupancy), 32'd1);
        applyStimulus(1'b0, 32'h0, 1'b0, 4'b0000, 1'b0); tick();
        applyStimulus(1'b1, 32'h11, 1'b0, 4'b0000, 1'b0); tick();
        checkOutput("collapse_occ2", 32'(bus.occupancy), 32'd2);
        applyStimulus(1'b0, 32'h0, 1'b0, 4'b0000, 1'b0); tick();
        applyStimulus(1'b1, 32'h12, 1'b0, 4'b0000, 1'b0); tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 4'b0000, 1'b0); tick();
        checkState("collapse_packed", 1'b1, 32'h10, 3);
        checkOutput("collapse_in_ready", 32'(bus.in_ready), 32'd1);
        applyStimulus(1'b0, 32'h0, 1'b1, 4'b0000, 1'b0);
        for (int j = 0; j < 3; j++) begin
            tick();
            if (j < 2) checkState("collapse_drain", 1'b1, 32'h11 + 32'(j), 2 - j);
            else       checkState("collapse_empty", 1'b0, NOP, 0);
        end

        $display("[TB] per-stage flush");
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 32'h20 + 32'(k), 1'b0, 4'b0000, 1'b0);
            tick();
        end
        checkState("flush_full", 1'b1, 32'h20, 4);
        applyStimulus(1'b0, 32'h0, 1'b0, 4'b0110, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 4'b0000, 1'b0);
        #1 checkState("flush_after", 1'b1, 32'h20, 2);
        applyStimulus(1'b0, 32'h0, 1'b1, 4'b0000, 1'b0);
        tick();
        checkState("flush_gap", 1'b0, NOP, 1);
        tick();
        checkState("flush_survivor", 1'b1, 32'h23, 1);
        tick();
        checkState("flush_empty", 1'b0, NOP, 0);

        $display("[TB] flush_all");
        applyStimulus(1'b1, 32'h40, 1'b0, 4'b0000, 1'b0); tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 4'b0000, 1'b0); tick();
        checkOutput("flush_all_pre_occ", 32'(bus.occupancy), 32'd1);
        applyStimulus(1'b1, 32'h55, 1'b1, 4'b0000, 1'b1);
        #1 checkOutput("flush_all_in_ready", 32'(bus.in_ready), 32'd0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b1, 4'b0000, 1'b0);
        #1 checkState("flush_all_after", 1'b0, NOP, 0);
        for (int j = 0; j < 3; j++) begin
            tick();
            checkOutput("flush_all_no_55", 32'(bus.out_valid), 32'd0);
        end

        $display("[TB] asynchronous reset mid-operation");
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 32'h60 + 32'(k), 1'b0, 4'b0000, 1'b0);
            tick();
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 4'b0000, 1'b0);
        checkState("pre_reset_full", 1'b1, 32'h60, 4);
        #2 reset = 1'b0;
        #1 checkState("async_reset", 1'b0, NOP, 0);
        #1 reset = 1'b1;
        applyStimulus(1'b1, 32'h77, 1'b1, 4'b0000, 1'b0);
        #1 checkOutput("post_reset_in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b1, 4'b0000, 1'b0);
        checkState("post_reset_e0", 1'b0, NOP, 1);
        for (int j = 1; j < 4; j++) begin
            tick();
            if (j < 3) checkOutput("post_reset_latency", 32'(bus.out_valid), 32'd0);
            else       checkState("post_reset_emerge", 1'b1, 32'h77, 1);
        end
        tick();
        checkState("post_reset_empty", 1'b0, NOP, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
